// File: rtl/mtimecmp_sched.sv
// -----------------------------------------------------------------------------
// mtimecmp_sched
//
// Software-timer scheduler for the machine timer. Holds NUM_SLOTS 64-bit
// deadlines, retires every deadline that mtime has reached, and keeps the
// timer's mtimecmp programmed with the earliest active deadline. mtimecmp is
// rewritten with the glitch-free 32-bit sequence hi=all-ones, lo, hi, so the
// compare never transiently matches while half-updated.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   arm_valid/slot/deadline     load a deadline into a slot and activate it
//   cancel_valid/slot           deactivate a slot (no expiry pulse)
//   time_rd_data[63:0]          current mtime value
//   wr_en/addr/wr_data/wr_strobe  timer register write port (2=lo, 3=hi)
//   expired[NUM_SLOTS]          one-cycle pulse per slot on expiry
//   slot_active[NUM_SLOTS]      valid bit of each slot
//   busy                        programming sequence in progress
// -----------------------------------------------------------------------------
module mtimecmp_sched #(
    parameter int NUM_SLOTS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arm_valid,
    input  logic [$clog2(NUM_SLOTS)-1:0] arm_slot,
    input  logic [63:0]                  arm_deadline,
    input  logic                         cancel_valid,
    input  logic [$clog2(NUM_SLOTS)-1:0] cancel_slot,
    input  logic [63:0]                  time_rd_data,
    output logic                         wr_en,
    output logic [1:0]                   addr,
    output logic [31:0]                  wr_data,
    output logic [3:0]                   wr_strobe,
    output logic [NUM_SLOTS-1:0]         expired,
    output logic [NUM_SLOTS-1:0]         slot_active,
    output logic                         busy
);

    localparam int SW = $clog2(NUM_SLOTS);

    localparam logic [1:0] ADDR_LO = 2'd2;
    localparam logic [1:0] ADDR_HI = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_WR_HI_MAX,
        S_WR_LO,
        S_WR_HI
    } state_e;

    state_e                 state_q, state_d;
    logic                   dirty_q, dirty_d;
    logic [63:0]            target_q, target_d;
    logic [NUM_SLOTS-1:0]   valid_q, valid_d;
    logic [63:0]            deadline_q [NUM_SLOTS];
    logic [63:0]            deadline_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   expire_now;
    logic                   event_now;
    logic [63:0]            earliest;

    logic                   wr_en_q, wr_en_d;
    logic [1:0]             addr_q, addr_d;
    logic [31:0]            wr_data_q, wr_data_d;
    logic [3:0]             wr_strobe_q, wr_strobe_d;
    logic [NUM_SLOTS-1:0]   expired_q;
    logic                   busy_q, busy_d;

    // Slot update: arm beats cancel beats expiry for the same slot. Any
    // change to the active set raises event_now, which marks mtimecmp stale.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        valid_d    = valid_q;
        deadline_d = deadline_q;
        expire_now = '0;
        event_now  = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (arm_valid && arm_slot == SW'(i)) begin
                valid_d[i]    = 1'b1;
                deadline_d[i] = arm_deadline;
                event_now     = 1'b1;
            end else if (cancel_valid && cancel_slot == SW'(i)) begin
                // Cancelling an idle slot changes nothing, so it must not
                // trigger a reprogram.
                if (valid_q[i]) begin
                    valid_d[i] = 1'b0;
                    event_now  = 1'b1;
                end
            end else if (valid_q[i] && deadline_q[i] <= time_rd_data) begin
                valid_d[i]    = 1'b0;
                expire_now[i] = 1'b1;
                event_now     = 1'b1;
            end
        end
    end

    // Earliest active deadline; all-ones parks mtimecmp where it never fires.
    always_comb begin
        earliest = '1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (valid_q[i] && deadline_q[i] < earliest) begin
                earliest = deadline_q[i];
            end
        end
    end

    // Programming FSM. IDLE and WR_HI look at dirty_d so a pending event
    // starts LATCH on the very next cycle with no idle bubble.
    always_comb begin
        state_d  = state_q;
        dirty_d  = dirty_q | event_now;
        target_d = target_q;
        unique case (state_q)
            S_IDLE: begin
                if (dirty_d) state_d = S_LATCH;
            end
            S_LATCH: begin
                target_d = earliest;
                // Only an event seen in this same cycle keeps the flag set.
                dirty_d  = event_now;
                state_d  = S_WR_HI_MAX;
            end
            S_WR_HI_MAX: state_d = S_WR_LO;
            S_WR_LO:     state_d = S_WR_HI;
            S_WR_HI:     state_d = dirty_d ? S_LATCH : S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Registered write port: decode from the next state so the strobe is
    // high in exactly the cycles the FSM sits in a write state.
    always_comb begin
        wr_en_d   = 1'b0;
        addr_d    = '0;
        wr_data_d = '0;
        unique case (state_d)
            S_WR_HI_MAX: begin
                wr_en_d   = 1'b1;
                addr_d    = ADDR_HI;
                wr_data_d = '1;
            end
            S_WR_LO: begin
                wr_en_d   = 1'b1;
                addr_d    = ADDR_LO;
                wr_data_d = target_d[31:0];
            end
            S_WR_HI: begin
                wr_en_d   = 1'b1;
                addr_d    = ADDR_HI;
                wr_data_d = target_d[63:32];
            end
            default: ;
        endcase
        wr_strobe_d = wr_en_d ? 4'hF : 4'h0;
        busy_d      = (state_d != S_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dirty_q     <= 1'b1;   // first pass after reset parks mtimecmp
            target_q    <= '0;
            valid_q     <= '0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            wr_strobe_q <= '0;
            expired_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dirty_q     <= dirty_d;
            target_q    <= target_d;
            valid_q     <= valid_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            wr_strobe_q <= wr_strobe_d;
            expired_q   <= expire_now;
            busy_q      <= busy_d;
        end
    end

    // NOTE: deadline storage is not reset; valid_q gates every use of it, so
    // its power-up contents are never observed.
    always_ff @(posedge clk) begin
        deadline_q <= deadline_d;
    end

    assign wr_en       = wr_en_q;
    assign addr        = addr_q;
    assign wr_data     = wr_data_q;
    assign wr_strobe   = wr_strobe_q;
    assign expired     = expired_q;
    assign slot_active = valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mtimecmp_sched.sv
// -----------------------------------------------------------------------------
// tb_mtimecmp_sched
//
// Directed bench for mtimecmp_sched. A shadow copy of mtimecmp is built from
// the write port, mimicking the timer block, and is used to confirm the value
// left behind by each programming pass and that lo is never written while hi
// is below all-ones.
// -----------------------------------------------------------------------------
module tb_mtimecmp_sched;

    localparam int NS = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            arm_valid = 1'b0;
    logic [1:0]      arm_slot = '0;
    logic [63:0]     arm_deadline = '0;
    logic            cancel_valid = 1'b0;
    logic [1:0]      cancel_slot = '0;
    logic [63:0]     time_rd_data = '0;
    logic            wr_en;
    logic [1:0]      addr;
    logic [31:0]     wr_data;
    logic [3:0]      wr_strobe;
    logic [NS-1:0]   expired;
    logic [NS-1:0]   slot_active;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] shadow;
    logic        glitch = 1'b0;

    mtimecmp_sched #(.NUM_SLOTS(NS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm_valid    (arm_valid),
        .arm_slot     (arm_slot),
        .arm_deadline (arm_deadline),
        .cancel_valid (cancel_valid),
        .cancel_slot  (cancel_slot),
        .time_rd_data (time_rd_data),
        .wr_en        (wr_en),
        .addr         (addr),
        .wr_data      (wr_data),
        .wr_strobe    (wr_strobe),
        .expired      (expired),
        .slot_active  (slot_active),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Timer-block model: mtimecmp resets to 0 and takes each 32-bit write.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (wr_en) begin
            if (addr == 2'd3) begin
                shadow[63:32] <= wr_data;
            end else if (addr == 2'd2) begin
                shadow[31:0] <= wr_data;
                if (shadow[63:32] !== 32'hFFFF_FFFF) glitch <= 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one three-write burst starting at the next edge and compares it.
    task automatic expect_writes(input string name, input logic [31:0] lo,
                                 input logic [31:0] hi);
        logic [1:0]  ea [3];
        logic [31:0] ed [3];
        ea[0] = 2'd3; ed[0] = 32'hFFFF_FFFF;
        ea[1] = 2'd2; ed[1] = lo;
        ea[2] = 2'd3; ed[2] = hi;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (wr_en !== 1'b1 || addr !== ea[k] || wr_data !== ed[k] || wr_strobe !== 4'hF) begin
                n_bad++;
                $display("FAIL %s write%0d: got en=%b addr=%0d data=%h strb=%h, want en=1 addr=%0d data=%h strb=f",
                         name, k, wr_en, addr, wr_data, wr_strobe, ea[k], ed[k]);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 40) begin
            tick();
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s wait_idle: busy=%b after %0d cycles, want 0", name, busy, k);
        end
    endtask

    task automatic expect_shadow(input string name, input logic [63:0] want);
        n_cmp++;
        if (shadow !== want) begin
            n_bad++;
            $display("FAIL %s mtimecmp: got %h want %h", name, shadow, want);
        end
    endtask

    // Called in the first cycle after reset release: LATCH then all-ones.
    task automatic expect_allones_pass(input string name);
        tick();
        n_cmp++;
        if (busy !== 1'b1 || wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL %s latch: busy=%b wr_en=%b, want busy=1 wr_en=0", name, busy, wr_en);
        end
        expect_writes(name, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        n_cmp++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || wr_strobe !== 4'h0) begin
            n_bad++;
            $display("FAIL %s end: busy=%b wr_en=%b strb=%h, want 0 0 0", name, busy, wr_en, wr_strobe);
        end
        expect_shadow(name, 64'hFFFF_FFFF_FFFF_FFFF);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({wr_en, addr, wr_data, wr_strobe, expired, slot_active, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_values: en=%b addr=%0d data=%h strb=%h exp=%b act=%b busy=%b, want all 0",
                     wr_en, addr, wr_data, wr_strobe, expired, slot_active, busy);
        end
        tick();
        tick();
        rst_n = 1'b1;
        expect_allones_pass("reset");
    endtask

    task automatic test_arm();
        arm_valid = 1'b1; arm_slot = 2'd1; arm_deadline = 64'h0000_0001_0000_0010;
        tick();
        arm_valid = 1'b0;
        n_cmp++;
        if (slot_active !== 4'b0010 || busy !== 1'b1 || wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL arm_latch: act=%b busy=%b wr_en=%b, want 0010 1 0", slot_active, busy, wr_en);
        end
        expect_writes("arm", 32'h0000_0010, 32'h0000_0001);
        tick();
        n_cmp++;
        if (busy !== 1'b0 || wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL arm_idle: busy=%b wr_en=%b, want 0 0", busy, wr_en);
        end
        expect_shadow("arm", 64'h0000_0001_0000_0010);
    endtask

    task automatic test_cancel();
        cancel_valid = 1'b1; cancel_slot = 2'd1;
        tick();
        cancel_valid = 1'b0;
        n_cmp++;
        if (slot_active !== 4'b0000 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL cancel: act=%b busy=%b, want 0000 1", slot_active, busy);
        end
        wait_idle("cancel");
        expect_shadow("cancel", 64'hFFFF_FFFF_FFFF_FFFF);
        // Cancelling an inactive slot must not start a pass.
        cancel_valid = 1'b1; cancel_slot = 2'd1;
        tick();
        cancel_valid = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL cancel_inactive: busy=%b wr_en=%b, want 0 0", busy, wr_en);
        end
    endtask

    task automatic test_expiry();
        arm_valid = 1'b1; arm_slot = 2'd0; arm_deadline = 64'd500;
        tick();
        arm_slot = 2'd2; arm_deadline = 64'd300;
        tick();
        arm_valid = 1'b0;
        wait_idle("min");
        expect_shadow("min", 64'd300);
        n_cmp++;
        if (slot_active !== 4'b0101) begin
            n_bad++;
            $display("FAIL min_active: got %b want 0101", slot_active);
        end
        time_rd_data = 64'd299;
        tick();
        n_cmp++;
        if (expired !== 4'b0000 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL t299: exp=%b busy=%b, want 0000 0", expired, busy);
        end
        time_rd_data = 64'd300;
        tick();
        n_cmp++;
        if (expired !== 4'b0100 || slot_active !== 4'b0001 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL t300: exp=%b act=%b busy=%b, want 0100 0001 1", expired, slot_active, busy);
        end
        tick();
        n_cmp++;
        if (expired !== 4'b0000) begin
            n_bad++;
            $display("FAIL t300_pulse: exp=%b want 0000", expired);
        end
        wait_idle("t300");
        expect_shadow("t300", 64'd500);
        time_rd_data = 64'd500;
        tick();
        n_cmp++;
        if (expired !== 4'b0001 || slot_active !== 4'b0000) begin
            n_bad++;
            $display("FAIL t500: exp=%b act=%b, want 0001 0000", expired, slot_active);
        end
        wait_idle("t500");
        expect_shadow("t500", 64'hFFFF_FFFF_FFFF_FFFF);
    endtask

    task automatic test_back_to_back();
        arm_valid = 1'b1; arm_slot = 2'd1; arm_deadline = 64'd1000;
        tick();                       // LATCH
        arm_valid = 1'b0;
        tick();                       // WR_HI_MAX
        tick();                       // WR_LO
        n_cmp++;
        if (wr_en !== 1'b1 || addr !== 2'd2 || wr_data !== 32'd1000) begin
            n_bad++;
            $display("FAIL b2b_lo: en=%b addr=%0d data=%h, want 1 2 %h", wr_en, addr, wr_data, 32'd1000);
        end
        arm_valid = 1'b1; arm_slot = 2'd3; arm_deadline = 64'd800;
        tick();                       // WR_HI of the first pass, unchanged
        arm_valid = 1'b0;
        n_cmp++;
        if (wr_en !== 1'b1 || addr !== 2'd3 || wr_data !== 32'd0) begin
            n_bad++;
            $display("FAIL b2b_hi: en=%b addr=%0d data=%h, want 1 3 0", wr_en, addr, wr_data);
        end
        tick();                       // LATCH with no idle bubble
        n_cmp++;
        if (busy !== 1'b1 || wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_latch: busy=%b wr_en=%b, want 1 0", busy, wr_en);
        end
        expect_writes("b2b", 32'd800, 32'd0);
        tick();
        n_cmp++;
        if (busy !== 1'b0 || slot_active !== 4'b1010) begin
            n_bad++;
            $display("FAIL b2b_end: busy=%b act=%b, want 0 1010", busy, slot_active);
        end
        expect_shadow("b2b", 64'd800);
    endtask

    task automatic test_same_cycle();
        time_rd_data = 64'd0;
        arm_valid = 1'b1; arm_slot = 2'd0; arm_deadline = 64'd100;
        tick();
        arm_valid = 1'b0;
        wait_idle("same_setup");
        expect_shadow("same_setup", 64'd100);
        time_rd_data = 64'd2000;
        arm_valid = 1'b1; arm_slot = 2'd0; arm_deadline = 64'd1000;
        cancel_valid = 1'b1; cancel_slot = 2'd0;
        tick();
        arm_valid = 1'b0;
        cancel_valid = 1'b0;
        // Slots 1 (1000) and 3 (800) retire; slot 0 is re-armed instead.
        n_cmp++;
        if (expired !== 4'b1010 || slot_active !== 4'b0001) begin
            n_bad++;
            $display("FAIL same_arm: exp=%b act=%b, want 1010 0001", expired, slot_active);
        end
        tick();
        n_cmp++;
        if (expired !== 4'b0001 || slot_active !== 4'b0000) begin
            n_bad++;
            $display("FAIL same_next: exp=%b act=%b, want 0001 0000", expired, slot_active);
        end
        wait_idle("same");
        expect_shadow("same", 64'hFFFF_FFFF_FFFF_FFFF);
    endtask

    task automatic test_reset_mid();
        arm_valid = 1'b1; arm_slot = 2'd2; arm_deadline = 64'd5000;
        tick();                       // LATCH
        arm_valid = 1'b0;
        tick();                       // WR_HI_MAX
        tick();                       // WR_LO
        n_cmp++;
        if (wr_en !== 1'b1 || addr !== 2'd2 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_pre: en=%b addr=%0d busy=%b, want 1 2 1", wr_en, addr, busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || slot_active !== 4'b0000 || wr_strobe !== 4'h0 || wr_data !== 32'h0) begin
            n_bad++;
            $display("FAIL rmid_async: en=%b busy=%b act=%b strb=%h data=%h, want 0 0 0000 0 0",
                     wr_en, busy, slot_active, wr_strobe, wr_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        expect_allones_pass("rmid");
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_arm();
        test_cancel();
        test_expiry();
        test_back_to_back();
        test_same_cycle();
        test_reset_mid();
        n_cmp++;
        if (glitch !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_free: lo written while hi below all-ones (flag=%b, want 0)", glitch);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
